fetch_stage: RTL

//  IF stage of the PPU: owns the program counter, drives inst_ram256x8 (256 B, byte-addressed, combinational read),
//  and loads the IF/ID pipeline register consumed by decode and the condition logic.

---
 rtl/fetch_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage: program counter, instruction-RAM drive and the IF/ID pipeline register.
// A taken branch redirects the PC and squashes the wrong-path fetch; the hazard unit can stall or bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          PC_INC    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_ld,
    input  logic        if_id_ld,
    input  logic        choose_ta_r_nop,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_nx, instr_nx, pc4_nx;
    logic        valid_nx;
    logic [31:0] pc_inc;

    assign pc_inc    = pc + 32'(PC_INC);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) state <= BOOT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = RUN;
        imem_en  = 1'b0;
        pc_nx    = pc;
        instr_nx = if_id_instr;
        pc4_nx   = if_id_pc4;
        valid_nx = if_id_valid;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                imem_en = 1'b1;
                if (choose_ta_r_nop) begin
                    // flush wins over any stall; target is forced word-aligned
                    pc_nx    = {branch_target[31:2], 2'b00};
                    instr_nx = NOP_INSTR;
                    valid_nx = 1'b0;
                end else begin
                    if (pc_ld) pc_nx = pc_inc;
                    if (if_id_ld) begin
                        if (pc_ld) begin
                            instr_nx = imem_data;
                            pc4_nx   = pc_inc;
                            valid_nx = 1'b1;
                        end else begin
                            instr_nx = NOP_INSTR;
                            valid_nx = 1'b0;
                        end
                    end
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_nx;
            if_id_instr <= instr_nx;
            if_id_pc4   <= pc4_nx;
            if_id_valid <= valid_nx;
        end
    end

endmodule
